// File: rtl/ex_stage.sv
// Execute stage of the RV32I five-stage pipeline.
// Selects forwarded operands, runs the ALU, resolves branches and jumps
// (the redirect to IF is combinational) and holds the EX/MEM register.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  // ID/EX control
  input  logic            MemReadE,
  input  logic            MemWriteE,
  input  logic            RegWriteE,
  input  logic            ALUSrcE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            MuxjalrE,
  input  logic [3:0]      ALUOpE,
  input  logic [2:0]      WriteBackE,
  input  logic [2:0]      funct3E,
  // ID/EX data
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  // hazard unit
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  // redirect to IF
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  // EX/MEM register
  output logic            MemReadM,
  output logic            MemWriteM,
  output logic            RegWriteM,
  output logic [2:0]      WriteBackM,
  output logic [2:0]      funct3M,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] PCTargetM,
  output logic [4:0]      RdM
);

  // ALU operation encodings
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1010;

  // Forwarding selector encodings (11 falls back to the register file value)
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Branch condition encodings (funct3)
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  logic [XLEN-1:0]        src_a;
  logic [XLEN-1:0]        fwd_b;
  logic [XLEN-1:0]        src_b;
  logic signed [XLEN-1:0] src_a_signed;
  logic [4:0]             shamt;
  logic                   alu_lt;
  logic                   alu_ltu;
  logic [XLEN-1:0]        alu_result;
  logic                   br_eq;
  logic                   br_lt;
  logic                   br_ltu;
  logic                   br_cond;
  logic [XLEN-1:0]        jalr_sum;
  logic [XLEN-1:0]        pc_rel_sum;

  // Operand A forwarding: MEM source is last cycle's registered ALU result
  always_comb begin
    case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
  end

  // Operand B forwarding; the forwarded value also feeds stores and branches
  always_comb begin
    case (ForwardBE)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_b        = ALUSrcE ? ImmExtE : fwd_b;
  assign src_a_signed = src_a;
  assign shamt        = src_b[4:0];
  assign alu_lt       = $signed(src_a) < $signed(src_b);
  assign alu_ltu      = src_a < src_b;

  // ALU: all arithmetic wraps, unused encodings fall back to ADD
  always_comb begin
    case (ALUOpE)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, alu_lt};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, alu_ltu};
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = src_a_signed >>> shamt;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_PASS: alu_result = src_b;
      default:  alu_result = src_a + src_b;
    endcase
  end

  // Branch comparisons use the forwarded rs2, never the immediate
  assign br_eq  = src_a == fwd_b;
  assign br_lt  = $signed(src_a) < $signed(fwd_b);
  assign br_ltu = src_a < fwd_b;

  // Branch condition decode; reserved funct3 values never take a branch
  always_comb begin
    case (funct3E)
      BR_EQ:   br_cond = br_eq;
      BR_NE:   br_cond = ~br_eq;
      BR_LT:   br_cond = br_lt;
      BR_GE:   br_cond = ~br_lt;
      BR_LTU:  br_cond = br_ltu;
      BR_GEU:  br_cond = ~br_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  // JALR target clears bit 0; branches and JAL are PC-relative
  assign jalr_sum   = src_a + ImmExtE;
  assign pc_rel_sum = PCE + ImmExtE;
  assign PCTargetE  = MuxjalrE ? {jalr_sum[XLEN-1:1], 1'b0} : pc_rel_sum;
  assign PCSrcE     = JumpE | (BranchE & br_cond);

  // EX/MEM register: loads every cycle, reset discards the in-flight instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MemReadM   <= 1'b0;
      MemWriteM  <= 1'b0;
      RegWriteM  <= 1'b0;
      WriteBackM <= 3'b000;
      funct3M    <= 3'b000;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      PCTargetM  <= '0;
      RdM        <= 5'd0;
    end else begin
      MemReadM   <= MemReadE;
      MemWriteM  <= MemWriteE;
      RegWriteM  <= RegWriteE;
      WriteBackM <= WriteBackE;
      funct3M    <= funct3E;
      ALUResultM <= alu_result;
      WriteDataM <= fwd_b;
      PCPlus4M   <= PCPlus4E;
      PCTargetM  <= PCTargetE;
      RdM        <= RdE;
    end
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32I 5-stage pipeline; sits directly downstream of the ID stage and its ID/EX register.
- Takes the ID/EX control and data outputs and selects operands through forwarding muxes.
- Computes the ALU result, resolves branches and jumps, and produces the PC redirect for IF.
- Registers everything MEM/WB needs in an internal EX/MEM pipeline register.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemReadE, MemWriteE, RegWriteE  in  1 each  memory/regfile controls from ID/EX.
- ALUSrcE  in  1  ALU operand B select: 0 = forwarded rs2, 1 = ImmExtE.
- JumpE, BranchE, MuxjalrE  in  1 each  jump, branch, JALR-target select.
- ALUOpE  in  4  ALU operation.
- WriteBackE  in  3  writeback select, passed through.
- funct3E  in  3  branch condition, also load/store size.
- RD1E, RD2E, PCE, ImmExtE, PCPlus4E  in  32 each  ID/EX data.
- RdE  in  5  destination register.
- ForwardAE, ForwardBE  in  2 each  from hazard unit: 00 = RDxE, 01 = ResultW, 10 = internal ALUResultM, 11 = treated as 00.
- ResultW  in  32  WB-stage result.
- PCSrcE  out  1  combinational redirect request to IF.
- PCTargetE  out  32  combinational redirect target.
- MemReadM, MemWriteM, RegWriteM  out  1 each  registered.
- WriteBackM, funct3M  out  3 each  registered.
- ALUResultM, WriteDataM, PCPlus4M, PCTargetM  out  32 each  registered.
- RdM  out  5  registered.

Behaviour:
- SrcA = fwd(ForwardAE, RD1E). FwdB = fwd(ForwardBE, RD2E). SrcB = ALUSrcE ? ImmExtE : FwdB.
- ALUOpE encoding:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT (signed), 0100 SLTU.
  - 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
  - 1010 pass SrcB (LUI); 1011-1111 behave as ADD.
- Shift amount = SrcB[4:0]. SLT/SLTU produce 32'h0 or 32'h1. All arithmetic wraps mod 2^32; there is no overflow flag.
- Branch compare always uses SrcA vs FwdB, never the immediate:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - funct3 010 and 011 give cond = 0.
- PCTargetE:
  - MuxjalrE = 1: (SrcA + ImmExtE) & 32'hFFFF_FFFE.
  - MuxjalrE = 0: PCE + ImmExtE.
- PCSrcE = JumpE | (BranchE & cond). Purely combinational, same cycle as the instruction in EX; no latency.
- EX/MEM register:
  - Loads on every rising clk edge; no enable.
  - WriteDataM = FwdB, so stores see forwarded data.
  - PCTargetM = PCTargetE, for AUIPC writeback selection downstream.
  - All other M outputs are the corresponding E values.
  - Latency from E inputs to M outputs is 1 cycle.
- Reset:
  - While reset = 0, all registered outputs are forced to 0 asynchronously: controls 0, RdM = 0, all data 0.
  - Reset mid-operation discards the in-flight EX instruction; no memory write or regfile write is issued.
  - The first edge after reset deasserts captures the current E inputs.
  - PCSrcE and PCTargetE stay combinational during reset; IF/PC reset priority handles them.
- Forwarding source 10 uses the register's own ALUResultM value, i.e. the previous cycle's result, not the current ALU output.
- A bubble (all-zero controls from ID/EX) propagates as a bubble. PCSrcE = 0 for a bubble.

Test Plan:
1. ADD with ALUSrcE = 0, RD1E = 5, RD2E = 7, RdE = 3, RegWriteE = 1 -> next edge ALUResultM = 12, RdM = 3, RegWriteM = 1.
2. Back-to-back dependency:
   - First instruction result 12 in ALUResultM.
   - Second instruction SUB with ForwardAE = 10, RD1E = 99, RD2E = 2 -> ALUResultM = 10.
   - Repeat with ForwardBE = 01, ResultW = 4 -> operand B = 4.
3. BEQ taken: BranchE = 1, funct3E = 000, RD1E = RD2E = 8, PCE = 0x100, ImmExtE = 0xFFFF_FFF0 -> PCSrcE = 1, PCTargetE = 0xF0. With RD2E = 9 -> PCSrcE = 0. BLT with 0xFFFF_FFFF vs 1 -> taken; BLTU -> not taken.
4. JALR: JumpE = 1, MuxjalrE = 1, RD1E = 0x203, ImmExtE = 4 -> PCTargetE = 0x206, PCSrcE = 1. PCPlus4E = 0x54 appears on PCPlus4M after 1 cycle.
5. SRA: SrcA = 0x8000_0000, SrcB = 0x24 (shamt 4) -> 0xF800_0000. SRL on the same operands -> 0x0800_0000. SLTU 1 vs 0xFFFF_FFFF -> 1.
6. Store with MemWriteE = 1 and ForwardBE = 01, ResultW = 0xDEAD_BEEF; assert reset low mid-cycle before the edge -> all M outputs go 0 immediately, MemWriteM never pulses. After release, the next edge captures the current inputs.
